// File: rtl/writeback_arbiter_if.sv
// Writeback bus between the execution units and the arbiter.
// Carries per-unit requests/acks and the register-file write port.
interface writeback_arbiter_if #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32
);
    localparam int PW = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]           unit_valid;
    logic [NUM_UNITS-1:0][4:0]      unit_rd_addr;
    logic [NUM_UNITS-1:0][XLEN-1:0] unit_data;
    logic [NUM_UNITS-1:0]           unit_ack;
    logic [4:0]                     rd_addr;
    logic [XLEN-1:0]                new_data;
    logic                           commit;
    logic [PW-1:0]                  rr_ptr_dbg;

    modport master (
        output unit_valid, unit_rd_addr, unit_data,
        input  unit_ack, rd_addr, new_data, commit, rr_ptr_dbg
    );

    modport slave (
        input  unit_valid, unit_rd_addr, unit_data,
        output unit_ack, rd_addr, new_data, commit, rr_ptr_dbg
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter feeding the single register-file write port.
// Ports: clk, rst (async active-low), bus (slave: unit requests in, acks and rd_addr/new_data/commit out).
module writeback_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32
) (
    input  logic                clk,
    input  logic                rst,
    writeback_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_UNITS);
    localparam logic [PW:0]   N_L  = (PW+1)'(NUM_UNITS);
    localparam logic [PW-1:0] LAST = PW'(NUM_UNITS - 1);

    logic [PW-1:0]        r_ptr;
    logic [4:0]           r_rd_addr;
    logic [XLEN-1:0]      r_data;
    logic                 r_commit;

    logic                 w_any;
    logic                 w_xfer;
    logic [PW-1:0]        w_gidx;
    logic [NUM_UNITS-1:0] w_ack;
    logic [PW:0]          w_sum;
    logic [PW-1:0]        w_idx;

    // Scan from r_ptr with wraparound; ptr and offset are both below
    // NUM_UNITS so one conditional subtract is enough.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= N_L) begin
                w_idx = PW'(w_sum - N_L);
            end else begin
                w_idx = PW'(w_sum);
            end
            if (!w_any && bus.unit_valid[w_idx]) begin
                w_any  = 1'b1;
                w_gidx = w_idx;
            end
        end
    end

    // Acks are held off combinationally while reset is asserted.
    assign w_xfer = w_any && rst;

    always_comb begin
        w_ack = '0;
        if (w_xfer) begin
            w_ack[w_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_rd_addr <= '0;
            r_data    <= '0;
            r_commit  <= 1'b0;
        end else if (w_xfer) begin
            r_ptr     <= (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
            r_rd_addr <= bus.unit_rd_addr[w_gidx];
            r_data    <= bus.unit_data[w_gidx];
            // x0 writes are consumed but never reach the register file.
            r_commit  <= (bus.unit_rd_addr[w_gidx] != 5'd0);
        end else begin
            r_commit  <= 1'b0;
        end
    end

    assign bus.unit_ack   = w_ack;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.new_data   = r_data;
    assign bus.commit     = r_commit;
    assign bus.rr_ptr_dbg = r_ptr;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios plus random traffic
// against a queue-free per-unit request model with rotating priority.
module tb_writeback_arbiter;
    localparam int N = 4;
    localparam int X = 32;

    logic clk;
    logic rst;

    writeback_arbiter_if #(.NUM_UNITS(N), .XLEN(X)) bus ();

    writeback_arbiter #(.NUM_UNITS(N), .XLEN(X)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    bit          pend  [N];
    logic [4:0]  paddr [N];
    logic [31:0] pdata [N];
    int          waitc [N];
    int          m_ptr;
    logic        e_commit;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int u = 0; u < N; u++) begin
            bus.unit_valid[u]   = pend[u];
            bus.unit_rd_addr[u] = paddr[u];
            bus.unit_data[u]    = pdata[u];
        end
    endtask

    task automatic req(input int u, input logic [4:0] a,
                       input logic [31:0] d);
        pend[u]  = 1'b1;
        paddr[u] = a;
        pdata[u] = d;
    endtask

    // One clock: check acks/pointer mid-cycle, optionally pull reset
    // before the edge, then check the registered write port after it.
    task automatic cycle(input bit rst_mid);
        int g;
        int u;
        drive();
        @(negedge clk);
        g = -1;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                u = (m_ptr + k) % N;
                if (pend[u] && g < 0) g = u;
            end
            chk("ack", bus.unit_ack, (g >= 0) ? (64'd1 << g) : 64'd0);
            chk("ptr", bus.rr_ptr_dbg, m_ptr);
        end else begin
            chk("rst_ack", bus.unit_ack, 0);
            chk("rst_ptr", bus.rr_ptr_dbg, 0);
            chk("rst_commit", bus.commit, 0);
        end
        if (rst_mid) begin
            rst = 1'b0;
            #1;
            chk("async_commit", bus.commit, 0);
            chk("async_ack", bus.unit_ack, 0);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            m_ptr    = 0;
            e_commit = 1'b0;
            e_addr   = '0;
            e_data   = '0;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else if (g >= 0) begin
            chk("fair", waitc[g] < N, 1);
            e_addr   = paddr[g];
            e_data   = pdata[g];
            e_commit = (paddr[g] != 0);
            m_ptr    = (g + 1) % N;
            pend[g]  = 1'b0;
            waitc[g] = 0;
            for (int i = 0; i < N; i++)
                if (pend[i]) waitc[i]++;
        end else begin
            e_commit = 1'b0;
        end
        chk("commit", bus.commit, e_commit);
        chk("rd_addr", bus.rd_addr, e_addr);
        chk("new_data", bus.new_data, e_data);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        m_ptr    = 0;
        e_commit = 1'b0;
        e_addr   = '0;
        e_data   = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; waitc[i] = 0;
        end
        rst = 1'b0;
        drive();

        // Reset with all units requesting: nothing may be acked.
        for (int i = 0; i < N; i++) req(i, 5'(i + 1), 32'hA0 + i);
        repeat (3) cycle(1'b0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        rst = 1'b1;
        cycle(1'b0);

        // Single write from unit 2.
        req(2, 5'd5, 32'hDEADBEEF);
        cycle(1'b0);
        chk("t2_commit", bus.commit, 1);
        chk("t2_addr", bus.rd_addr, 5);
        chk("t2_data", bus.new_data, 32'hDEADBEEF);
        chk("t2_ptr", bus.rr_ptr_dbg, 3);
        cycle(1'b0);

        // Bring pointer to 0, then full contention.
        req(3, 5'd20, 32'h33);
        cycle(1'b0);
        chk("t3_ptr0", bus.rr_ptr_dbg, 0);
        for (int i = 0; i < N; i++) req(i, 5'(i + 1), 32'h100 + i);
        for (int i = 0; i < N; i++) begin
            cycle(1'b0);
            chk("t3_seq", bus.rd_addr, i + 1);
        end
        chk("t3_wrap", bus.rr_ptr_dbg, 0);

        // x0 write from unit 1 with unit 3 queued behind it.
        req(1, 5'd0, 32'h1234);
        req(3, 5'd9, 32'h9999);
        cycle(1'b0);
        chk("t4_nocommit", bus.commit, 0);
        chk("t4_ptr", bus.rr_ptr_dbg, 2);
        cycle(1'b0);
        chk("t4_next", bus.commit, 1);
        chk("t4_addr", bus.rd_addr, 9);

        // Pointer at 3, units 0 and 3 valid: 3 then 0.
        req(2, 5'd2, 32'h22);
        cycle(1'b0);
        req(0, 5'd10, 32'hA);
        req(3, 5'd13, 32'hD);
        cycle(1'b0);
        chk("t5_first", bus.rd_addr, 13);
        cycle(1'b0);
        chk("t5_second", bus.rd_addr, 10);
        chk("t5_commit", bus.commit, 1);

        // Reset lands between the rd 7 handshake and its commit edge.
        req(1, 5'd7, 32'h77);
        cycle(1'b1);
        chk("t6_drop", bus.commit, 0);
        rst = 1'b1;
        cycle(1'b0);
        chk("t6_redo", bus.commit, 1);
        chk("t6_addr", bus.rd_addr, 7);

        // Random traffic with occasional x0 targets and resets.
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && $urandom_range(0, 2) != 0) begin
                    req(u,
                        ($urandom_range(0, 4) == 0) ? 5'd0
                            : 5'($urandom_range(1, 31)),
                        $urandom);
                end
            end
            if (!rst) rst = 1'b1;
            cycle($urandom_range(0, 60) == 0);
        end
        rst = 1'b1;
        cycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
